// File: rtl/button_pulse_ctrl.sv
// Push-button front end: 2-FF synchroniser, tick-gated debouncer and per-button press/release/hold
// event FSM. Define BTN_AUTO_REPEAT_EN to build in the auto-repeat pulse generator.
module button_pulse_ctrl #(
    parameter int unsigned NUM_BTN      = 5,
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned DEB_SAMPLES  = 4,
    parameter int unsigned HOLD_TICKS   = 500,
    parameter int unsigned REPEAT_TICKS = 100
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_hold,
    output logic [NUM_BTN-1:0] btn_repeat,
    output logic               sample_tick
);

    localparam int unsigned      TickW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
    localparam int unsigned      HoldW   = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_TICKS);

    typedef enum logic [1:0] {StIdle, StDown, StHeld} btn_state_e;

    logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [NUM_BTN-1:0] sync_meta_q, sync_q;

    always_comb begin
        sample_tick = (tick_cnt_q == TickMax);
        tick_cnt_d  = sample_tick ? '0 : tick_cnt_q + TickW'(1);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            tick_cnt_q  <= '0;
            sync_meta_q <= '0;
            sync_q      <= '0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            sync_meta_q <= btn_in;
            sync_q      <= sync_meta_q;
        end
    end

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        logic [DEB_SAMPLES-1:0] deb_q, deb_d;
        logic                   level_q, level_d;
        btn_state_e             state_q, state_d;
        logic [HoldW-1:0]       hold_cnt_q, hold_cnt_d;
        logic                   press_ev, rel_ev, hold_ev;

        // The level only moves once DEB_SAMPLES consecutive tick samples agree.
        always_comb begin
            deb_d   = deb_q;
            level_d = level_q;
            if (sample_tick) begin
                deb_d = {deb_q[DEB_SAMPLES-2:0], sync_q[b]};
                if (&deb_d) begin
                    level_d = 1'b1;
                end else if (~|deb_d) begin
                    level_d = 1'b0;
                end
            end
        end

        // Events are decoded from the registered state and level, so each fires in the
        // cycle right after the tick that caused it and lasts exactly one clock.
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            press_ev   = 1'b0;
            rel_ev     = 1'b0;
            hold_ev    = 1'b0;
            case (state_q)
                StIdle: begin
                    hold_cnt_d = '0;
                    if (level_q) begin
                        press_ev = 1'b1;
                        state_d  = StDown;
                    end
                end
                StDown: begin
                    if (!level_q) begin
                        rel_ev  = 1'b1;
                        state_d = StIdle;
                    end else if (hold_cnt_q == HoldMax) begin
                        hold_ev = 1'b1;
                        state_d = StHeld;
                    end else if (sample_tick) begin
                        hold_cnt_d = hold_cnt_q + HoldW'(1);
                    end
                end
                StHeld: begin
                    if (!level_q) begin
                        rel_ev  = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        always_ff @(posedge clock) begin
            if (!resetn) begin
                deb_q      <= '0;
                level_q    <= 1'b0;
                state_q    <= StIdle;
                hold_cnt_q <= '0;
            end else begin
                deb_q      <= deb_d;
                level_q    <= level_d;
                state_q    <= state_d;
                hold_cnt_q <= hold_cnt_d;
            end
        end

        assign btn_level[b]   = level_q;
        assign btn_press[b]   = press_ev;
        assign btn_release[b] = rel_ev;
        assign btn_hold[b]    = hold_ev;

`ifdef BTN_AUTO_REPEAT_EN
        localparam int unsigned    RepW   = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
        localparam logic [RepW-1:0] RepMax = RepW'(REPEAT_TICKS);

        logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
        logic            rep_ev;

        // Counter sits at zero outside HELD, so every entry starts a fresh interval.
        always_comb begin
            rep_cnt_d = '0;
            rep_ev    = 1'b0;
            if (state_q == StHeld && level_q) begin
                if (rep_cnt_q == RepMax) begin
                    rep_ev = 1'b1;
                end else if (sample_tick) begin
                    rep_cnt_d = rep_cnt_q + RepW'(1);
                end else begin
                    rep_cnt_d = rep_cnt_q;
                end
            end
        end

        always_ff @(posedge clock) begin
            if (!resetn) begin
                rep_cnt_q <= '0;
            end else begin
                rep_cnt_q <= rep_cnt_d;
            end
        end

        assign btn_repeat[b] = rep_ev;
`else
        assign btn_repeat[b] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_button_pulse_ctrl.sv
// Directed bench for button_pulse_ctrl: reset, debounce, hold, short press, repeat, mid-hold reset.
module tb_button_pulse_ctrl;

    localparam int unsigned NB = 2;
    localparam int unsigned TD = 4;

    logic          clock  = 1'b0;
    logic          resetn = 1'b0;
    logic [NB-1:0] btn_in = 2'b11;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_hold, btn_repeat;
    logic          sample_tick;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;
    int unsigned overlap_n = 0;

    int unsigned press_n [NB] = '{0, 0};
    int unsigned rel_n   [NB] = '{0, 0};
    int unsigned hold_n  [NB] = '{0, 0};
    int unsigned rep_n   [NB] = '{0, 0};
    int unsigned press_at [NB] = '{0, 0};
    int unsigned hold_at  [NB] = '{0, 0};
    int unsigned rep_at   [NB] = '{0, 0};

    int unsigned press_s [NB];
    int unsigned rel_s   [NB];
    int unsigned hold_s  [NB];
    int unsigned rep_s   [NB];

    button_pulse_ctrl #(
        .NUM_BTN      (NB),
        .TICK_DIV     (TD),
        .DEB_SAMPLES  (3),
        .HOLD_TICKS   (5),
        .REPEAT_TICKS (2)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_hold    (btn_hold),
        .btn_repeat  (btn_repeat),
        .sample_tick (sample_tick)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Event recorder, sampled mid-cycle.
    always @(negedge clock) begin
        for (int b = 0; b < NB; b++) begin
            int unsigned ev;
            ev = 0;
            if (btn_press[b] === 1'b1) begin
                press_n[b] <= press_n[b] + 1;
                press_at[b] <= cyc;
                ev++;
            end
            if (btn_release[b] === 1'b1) begin
                rel_n[b] <= rel_n[b] + 1;
                ev++;
            end
            if (btn_hold[b] === 1'b1) begin
                hold_n[b] <= hold_n[b] + 1;
                hold_at[b] <= cyc;
                ev++;
            end
            if (btn_repeat[b] === 1'b1) begin
                rep_n[b] <= rep_n[b] + 1;
                rep_at[b] <= cyc;
                ev++;
            end
            if (ev > 1) overlap_n <= overlap_n + 1;
        end
    end

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    // Returns mid-cycle inside the n-th tick cycle seen.
    task automatic wait_ticks(input int n);
        int seen;
        int budget;
        seen   = 0;
        budget = n * TD + 8;
        while (seen < n && budget > 0) begin
            step(1);
            budget--;
            if (sample_tick === 1'b1) seen++;
        end
        if (seen < n) check_eq("tick_timeout", seen, n);
    endtask

    task automatic snap();
        for (int b = 0; b < NB; b++) begin
            press_s[b] = press_n[b];
            rel_s[b]   = rel_n[b];
            hold_s[b]  = hold_n[b];
            rep_s[b]   = rep_n[b];
        end
    endtask

    function automatic int unsigned all_outs();
        return 32'({btn_level, btn_press, btn_release, btn_hold, btn_repeat, sample_tick});
    endfunction

    // Release with reset just asserted elsewhere; wait for both presses, return latency.
    task automatic wait_both_press(output int unsigned k);
        k = 0;
        while ((press_n[0] == press_s[0] || press_n[1] == press_s[1]) && k < 20) begin
            step(1);
            k++;
        end
    endtask

    initial begin
        int unsigned k;
        int unsigned t0;

        // 1. Reset with both buttons pressed.
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_eq("rst_outputs_zero", all_outs(), 0);
        end
        snap();
        resetn = 1'b1;
        wait_both_press(k);
        check_eq("rst_press_latency", k, 12);
        check_eq("rst_press0_once", press_n[0] - press_s[0], 1);
        check_eq("rst_press1_once", press_n[1] - press_s[1], 1);
        check_eq("rst_press_same_cyc", press_at[0], press_at[1]);
        check_eq("rst_level", 32'(btn_level), 3);
        check_eq("rst_no_release", rel_n[0] + rel_n[1], 0);

        wait_ticks(1);
        t0 = cyc;
        snap();
        btn_in = 2'b00;
        wait_ticks(1);
        check_eq("tick_period", cyc - t0, TD);
        wait_ticks(2);
        step(2);
        check_eq("rst_rel0", rel_n[0] - rel_s[0], 1);
        check_eq("rst_rel1", rel_n[1] - rel_s[1], 1);
        check_eq("rst_no_hold", hold_n[0] + hold_n[1], 0);
        check_eq("rst_level_low", 32'(btn_level), 0);

        // 2. Debounce: 2 high, 1 low, 3 high.
        wait_ticks(1);
        snap();
        btn_in = 2'b01;
        wait_ticks(2);
        btn_in = 2'b00;
        wait_ticks(1);
        btn_in = 2'b01;
        wait_ticks(2);
        check_eq("deb_level_still_low", 32'(btn_level[0]), 0);
        check_eq("deb_no_early_press", press_n[0] - press_s[0], 0);
        wait_ticks(1);
        step(2);
        check_eq("deb_press_once", press_n[0] - press_s[0], 1);
        check_eq("deb_level_high", 32'(btn_level[0]), 1);
        check_eq("deb_btn1_quiet", press_n[1] - press_s[1], 0);
        wait_ticks(1);
        btn_in = 2'b00;
        wait_ticks(3);
        step(2);
        check_eq("deb_release", rel_n[0] - rel_s[0], 1);

        // 3. Hold then release.
        wait_ticks(1);
        snap();
        btn_in = 2'b01;
        wait_ticks(10);
        step(2);
        check_eq("hold_press", press_n[0] - press_s[0], 1);
        check_eq("hold_once", hold_n[0] - hold_s[0], 1);
        check_eq("hold_delay", hold_at[0] - press_at[0], 5 * TD);
        check_eq("hold_no_release", rel_n[0] - rel_s[0], 0);
        wait_ticks(1);
        btn_in = 2'b00;
        wait_ticks(3);
        step(2);
        check_eq("hold_release", rel_n[0] - rel_s[0], 1);
        wait_ticks(2);
        check_eq("hold_not_again", hold_n[0] - hold_s[0], 1);

        // 4. Short press.
        wait_ticks(1);
        snap();
        btn_in = 2'b01;
        wait_ticks(4);
        btn_in = 2'b00;
        wait_ticks(3);
        step(2);
        check_eq("short_press", press_n[0] - press_s[0], 1);
        check_eq("short_release", rel_n[0] - rel_s[0], 1);
        check_eq("short_no_hold", hold_n[0] - hold_s[0], 0);

        // 5. Auto-repeat.
        wait_ticks(1);
        snap();
        btn_in = 2'b01;
        wait_ticks(12);
        step(2);
        check_eq("rep_hold", hold_n[0] - hold_s[0], 1);
`ifdef BTN_AUTO_REPEAT_EN
        check_eq("rep_count", rep_n[0] - rep_s[0], 2);
        check_eq("rep_last_delay", rep_at[0] - hold_at[0], 4 * TD);
`else
        check_eq("rep_absent", rep_n[0] + rep_n[1], 0);
`endif
        wait_ticks(1);
        btn_in = 2'b00;
        wait_ticks(3);
        step(2);
        check_eq("rep_release", rel_n[0] - rel_s[0], 1);

        // 6. Reset while both buttons are HELD.
        wait_ticks(1);
        snap();
        btn_in = 2'b11;
        wait_ticks(10);
        step(2);
        check_eq("mid_hold0", hold_n[0] - hold_s[0], 1);
        check_eq("mid_hold1", hold_n[1] - hold_s[1], 1);
        snap();
        resetn = 1'b0;
        step(3);
        check_eq("mid_rst_outputs_zero", all_outs(), 0);
        check_eq("mid_rst_no_release", (rel_n[0] - rel_s[0]) + (rel_n[1] - rel_s[1]), 0);
        resetn = 1'b1;
        wait_both_press(k);
        check_eq("mid_fresh_press_latency", k, 12);
        check_eq("mid_fresh_press0", press_n[0] - press_s[0], 1);
        check_eq("mid_fresh_press1", press_n[1] - press_s[1], 1);
        check_eq("mid_still_no_release", (rel_n[0] - rel_s[0]) + (rel_n[1] - rel_s[1]), 0);

        check_eq("one_event_per_btn", overlap_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
